// File: rtl/state_machine_sel4.sv
// Purpose : 4-state Moore mode selector. The next state comes from a priority encode of
//           request inputs a3 > a2 > a1 > a0, qualified by en.
// Latency : 1 clock from the sampled en/a inputs to state/y1/y0. Outputs are driven
//           only by the state register.
// Backpressure: none. en=0 or no asserted request holds the current state.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (forces S0, overrides en and all requests)
//   en         state-update enable (0 = hold)
//   a0..a3     requests for S0..S3
//   y1, y0     binary-encoded current state (registered)
//   state      current state register {y1,y0}
//   err        (only when STATE_MACHINE_ONEHOT_CHK_EN is defined) registered one-cycle
//              flag for an enabled edge that sees more than one request; that edge holds
//              the state
//
// Build option: STATE_MACHINE_ONEHOT_CHK_EN adds the one-hot request check and the err port.
module state_machine_sel4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    output logic       y0,
    output logic       y1,
    output logic [1:0] state
`ifdef STATE_MACHINE_ONEHOT_CHK_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    // Priority-encoded request: req_vld says some request is asserted, and req_tgt is
    // the winning state.
    logic   req_vld;
    state_t req_tgt;

    // More than one request asserted at the same time.
    logic   req_multi;

    always_comb begin
        req_vld = a0 | a1 | a2 | a3;
        req_tgt = S0;
        if (a3) begin
            req_tgt = S3;
        end else if (a2) begin
            req_tgt = S2;
        end else if (a1) begin
            req_tgt = S1;
        end else begin
            req_tgt = S0;
        end
        req_multi = (a0 & a1) | (a0 & a2) | (a0 & a3)
                  | (a1 & a2) | (a1 & a3) | (a2 & a3);
    end

`ifdef STATE_MACHINE_ONEHOT_CHK_EN
    // With the check enabled, a multi-request edge is not a legal move. It freezes the
    // state and raises err, so the winner is never taken.
    logic take;
    assign take = en & req_vld & ~req_multi;
`else
    logic take;
    assign take = en & req_vld;
`endif

    // Next-state logic. Every state can move to any other state. The case on state_q
    // keeps a per-state arm so that a later state-specific rule has an obvious home.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: if (take) state_d = req_tgt;
            S1: if (take) state_d = req_tgt;
            S2: if (take) state_d = req_tgt;
            S3: if (take) state_d = req_tgt;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef STATE_MACHINE_ONEHOT_CHK_EN
    logic err_q;
    logic err_d;

    // err is raised only on an enabled edge. With en=0 the request lines are ignored.
    always_comb begin
        err_d = en & req_multi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // req_multi only matters to the one-hot check.
    logic unused_multi;
    assign unused_multi = req_multi;
`endif

    assign state = state_q;
    assign y1    = state_q[1];
    assign y0    = state_q[0];

endmodule

// File: tb/tb_state_machine_sel4.sv
module tb_state_machine_sel4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       a0  = 1'b0;
    logic       a1  = 1'b0;
    logic       a2  = 1'b0;
    logic       a3  = 1'b0;
    logic       y0;
    logic       y1;
    logic [1:0] state;
`ifdef STATE_MACHINE_ONEHOT_CHK_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] st;
        logic       er;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   vec_idx = 0;

    state_machine_sel4 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .y0    (y0),
        .y1    (y1),
        .state (state)
`ifdef STATE_MACHINE_ONEHOT_CHK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs are applied at the falling edge. The expected result after the next rising
    // edge is pushed at the same time.
    // a is {a3,a2,a1,a0}. exp_d is the default-build state; exp_m and exp_e are the
    // state and err for the one-hot-check build.
    task automatic step(input logic r, input logic e, input logic [3:0] a,
                        input logic [1:0] exp_d, input logic [1:0] exp_m,
                        input logic exp_e);
        exp_t x;
        @(negedge clk);
        rst = r;
        en  = e;
        {a3, a2, a1, a0} = a;
`ifdef STATE_MACHINE_ONEHOT_CHK_EN
        x.st = exp_m;
        x.er = exp_e;
`else
        x.st = exp_d;
        x.er = 1'b0;
`endif
        x.idx = vec_idx;
        vec_idx++;
        exp_q.push_back(x);
    endtask

    // Monitor: every rising edge presents a new registered state. Sample it 1 time unit
    // later and check it against the oldest expectation in the queue.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (state !== x.st) begin
                errors++;
                $display("FAIL state vec%0d: got %b expected %b", x.idx, state, x.st);
            end
            checks++;
            if ({y1, y0} !== x.st) begin
                errors++;
                $display("FAIL y1y0 vec%0d: got %b expected %b", x.idx, {y1, y0}, x.st);
            end
`ifdef STATE_MACHINE_ONEHOT_CHK_EN
            checks++;
            if (err !== x.er) begin
                errors++;
                $display("FAIL err vec%0d: got %b expected %b", x.idx, err, x.er);
            end
`endif
        end
    end

    initial begin
        // Reset has priority over every request.
        step(1, 1, 4'b1111, 2'b00, 2'b00, 0);
        // All requests asserted: a3 wins, or the check build holds and flags err.
        step(0, 1, 4'b1111, 2'b11, 2'b00, 1);
        step(1, 0, 4'b0000, 2'b00, 2'b00, 0);
        // en=0 holds the state.
        step(0, 0, 4'b0001, 2'b00, 2'b00, 0);
        step(0, 0, 4'b1000, 2'b00, 2'b00, 0);
        step(0, 0, 4'b1000, 2'b00, 2'b00, 0);
        // Single requests.
        step(0, 1, 4'b0010, 2'b01, 2'b01, 0);
        step(0, 1, 4'b0100, 2'b10, 2'b10, 0);
        step(0, 1, 4'b0100, 2'b10, 2'b10, 0);
        step(0, 1, 4'b1000, 2'b11, 2'b11, 0);
        step(0, 1, 4'b1000, 2'b11, 2'b11, 0);
        // Priority cases: the check build holds S3 and flags err.
        step(0, 1, 4'b0101, 2'b10, 2'b11, 1);
        step(0, 1, 4'b0011, 2'b01, 2'b11, 1);
        // No request asserted: hold.
        step(0, 1, 4'b0000, 2'b01, 2'b11, 0);
        // en=0 with several requests: hold, and no err.
        step(0, 0, 4'b1111, 2'b01, 2'b11, 0);
        step(0, 1, 4'b0001, 2'b00, 2'b00, 0);
        step(0, 1, 4'b1000, 2'b11, 2'b11, 0);
        // Reset asserted mid-run from S3, then released.
        step(1, 1, 4'b1000, 2'b00, 2'b00, 0);
        step(0, 1, 4'b1000, 2'b11, 2'b11, 0);
        // a1 with a3, then a1 alone.
        step(0, 1, 4'b1010, 2'b11, 2'b11, 1);
        step(0, 1, 4'b0010, 2'b01, 2'b01, 0);
        step(0, 1, 4'b0100, 2'b10, 2'b10, 0);
        step(0, 1, 4'b0001, 2'b00, 2'b00, 0);

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000");
        $fatal(1);
    end

endmodule
